// File: rtl/approx_adder_error_monitor_pkg.sv
// ---------------------------------------------------------------------------
// approx_arith_pkg
// Shared definitions for the approximate-adder error monitor.
//   DEF_DATA_W  : default operand width of the adders being characterised
//   DEF_RES_W   : width of a full sum / error distance (carry kept)
//   mon_state_e : monitor control states
//   abs_diff    : unsigned |a - b| at DEF_RES_W bits
// ---------------------------------------------------------------------------
package approx_arith_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RES_W  = DEF_DATA_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SAT   = 2'd1,
        ST_CLEAR = 2'd2
    } mon_state_e;

    function automatic logic [DEF_RES_W-1:0] abs_diff(
        input logic [DEF_RES_W-1:0] a,
        input logic [DEF_RES_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// ---------------------------------------------------------------------------
// approx_adder_error_monitor_if
// Sample bus from an approximate adder into the error monitor.
//   valid  : sample valid (upstream drives)
//   ready  : monitor can accept (monitor drives); transfer on valid && ready
//   add1   : operand A
//   add2   : operand B
//   approx : approximate adder result for add1 + add2 (DATA_W+1 bits)
// Modports: master = upstream producer, slave = monitor.
// ---------------------------------------------------------------------------
interface approx_adder_error_monitor_if #(
    parameter int DATA_W = approx_arith_pkg::DEF_DATA_W
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] add1;
    logic [DATA_W-1:0] add2;
    logic [DATA_W:0]   approx;

    modport master (output valid, output add1, output add2, output approx, input ready);
    modport slave  (input valid, input add1, input add2, input approx, output ready);
endinterface

// File: rtl/approx_err_stats.sv
// ---------------------------------------------------------------------------
// approx_err_stats
// Stage 2 of the monitor: error distance per sample plus the statistics bank.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous clear; wins over a simultaneous update
//   valid_i       : stage-1 sample valid
//   exact_i       : exact sum (carry kept)
//   approx_i      : approximate adder result
//   ed_valid_o    : one-cycle pulse with ed_o / err_flag_o
//   ed_o          : |exact - approx|
//   err_flag_o    : ed_o != 0
//   sample_cnt_o  : retired samples
//   err_cnt_o     : retired samples with nonzero ED
//   max_ed_o      : largest ED seen
//   sum_ed_o      : saturating ED sum
//   sat_o         : sticky saturation flag
// ---------------------------------------------------------------------------
module approx_err_stats
    import approx_arith_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 48
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W:0]   exact_i,
    input  logic [DATA_W:0]   approx_i,
    output logic              ed_valid_o,
    output logic [DATA_W:0]   ed_o,
    output logic              err_flag_o,
    output logic [CNT_W-1:0]  sample_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [DATA_W:0]   max_ed_o,
    output logic [ACC_W-1:0]  sum_ed_o,
    output logic              sat_o
);

    logic              ed_valid_q, ed_valid_d;
    logic [DATA_W:0]   ed_q, ed_d;
    logic              err_flag_q, err_flag_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W:0]   max_ed_q, max_ed_d;
    logic [ACC_W-1:0]  sum_ed_q, sum_ed_d;
    logic              sat_q, sat_d;

    logic [DATA_W:0]   ed_cur;
    logic [CNT_W-1:0]  sample_inc;
    logic [ACC_W:0]    sum_ext;

    // The package helper is fixed at the default width; other widths use the
    // same expression locally.
    if (DATA_W == DEF_DATA_W) begin : g_pkg_abs
        assign ed_cur = abs_diff(exact_i, approx_i);
    end else begin : g_local_abs
        assign ed_cur = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);
    end

    assign sample_inc = sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // One extra bit catches accumulator overflow.
    assign sum_ext    = {1'b0, sum_ed_q} + {{(ACC_W-DATA_W){1'b0}}, ed_cur};

    // Once saturated, the ED pulse still reports retiring samples but the
    // statistics freeze so nothing wraps.
    always_comb begin
        ed_valid_d   = 1'b0;
        ed_d         = ed_q;
        err_flag_d   = err_flag_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        max_ed_d     = max_ed_q;
        sum_ed_d     = sum_ed_q;
        sat_d        = sat_q;
        if (clear_i) begin
            ed_d         = '0;
            err_flag_d   = 1'b0;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            max_ed_d     = '0;
            sum_ed_d     = '0;
            sat_d        = 1'b0;
        end else if (valid_i) begin
            ed_valid_d = 1'b1;
            ed_d       = ed_cur;
            err_flag_d = |ed_cur;
            if (!sat_q) begin
                sample_cnt_d = sample_inc;
                if (&sample_inc) begin
                    sat_d = 1'b1;
                end
                if (|ed_cur) begin
                    err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (ed_cur > max_ed_q) begin
                    max_ed_d = ed_cur;
                end
                if (sum_ext[ACC_W]) begin
                    sum_ed_d = '1;
                    sat_d    = 1'b1;
                end else begin
                    sum_ed_d = sum_ext[ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ed_valid_q   <= 1'b0;
            ed_q         <= '0;
            err_flag_q   <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_ed_q     <= '0;
            sum_ed_q     <= '0;
            sat_q        <= 1'b0;
        end else begin
            ed_valid_q   <= ed_valid_d;
            ed_q         <= ed_d;
            err_flag_q   <= err_flag_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_ed_q     <= max_ed_d;
            sum_ed_q     <= sum_ed_d;
            sat_q        <= sat_d;
        end
    end

    assign ed_valid_o   = ed_valid_q;
    assign ed_o         = ed_q;
    assign err_flag_o   = err_flag_q;
    assign sample_cnt_o = sample_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign max_ed_o     = max_ed_q;
    assign sum_ed_o     = sum_ed_q;
    assign sat_o        = sat_q;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// ---------------------------------------------------------------------------
// approx_adder_error_monitor
// Characterises an approximate adder against its live operand stream:
// computes the exact sum, the error distance and running error statistics.
// Latency two cycles from accept to ed_o / statistics, one sample per cycle.
//   clk_i, rst_ni   : clock, async active-low reset
//   clear_i         : synchronous clear of pipeline and statistics
//   smp (slave)     : valid/ready sample bus with add1, add2, approx
//   ed_valid_o .. sat_o : see approx_err_stats
// ---------------------------------------------------------------------------
module approx_adder_error_monitor
    import approx_arith_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 48
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    approx_adder_error_monitor_if.slave smp,
    output logic              ed_valid_o,
    output logic [DATA_W:0]   ed_o,
    output logic              err_flag_o,
    output logic [CNT_W-1:0]  sample_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [DATA_W:0]   max_ed_o,
    output logic [ACC_W-1:0]  sum_ed_o,
    output logic              sat_o
);

    mon_state_e      state_q, state_d;
    logic            s1_valid_q, s1_valid_d;
    logic [DATA_W:0] exact_q, exact_d;
    logic [DATA_W:0] approx_q, approx_d;
    logic            accept;

    // Gating on rst_ni keeps ready low during reset; gating on sat_o closes
    // the door as soon as the flag sets, before the FSM reaches SAT.
    assign smp.ready = rst_ni && (state_q == ST_RUN) && !clear_i && !sat_o;
    assign accept    = smp.valid && smp.ready;

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_RUN:   if (sat_o) state_d = ST_SAT;
                ST_SAT:   state_d = ST_SAT;
                ST_CLEAR: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Data registers load only on accept, so idle bus contents never reach
    // the statistics.
    always_comb begin
        s1_valid_d = 1'b0;
        exact_d    = exact_q;
        approx_d   = approx_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            exact_d    = {1'b0, smp.add1} + {1'b0, smp.add2};
            approx_d   = smp.approx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            s1_valid_q <= 1'b0;
            exact_q    <= '0;
            approx_q   <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            exact_q    <= exact_d;
            approx_q   <= approx_d;
        end
    end

    approx_err_stats #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) u_stats (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .valid_i      (s1_valid_q),
        .exact_i      (exact_q),
        .approx_i     (approx_q),
        .ed_valid_o   (ed_valid_o),
        .ed_o         (ed_o),
        .err_flag_o   (err_flag_o),
        .sample_cnt_o (sample_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .max_ed_o     (max_ed_o),
        .sum_ed_o     (sum_ed_o),
        .sat_o        (sat_o)
    );

endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Downstream consumer of the 32-bit approximate adders (almost_correct_adder32 and siblings). Each accepted sample carries both operands and the approximate adder's result.
- Computes the exact sum and the error distance (ED) per sample, then accumulates error statistics (sample count, error count, max ED, sum of ED) in a 2-stage pipeline.
- Used in silicon and in simulation to characterise adder accuracy against the live operand stream.

Parameters:
- DATA_W, 32, operand width; result and ED are DATA_W+1 bits.
- CNT_W, 32, width of the sample and error counters.
- ACC_W, 48, width of the ED accumulator.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- valid_i  in  1  sample valid.
- ready_o  out  1  monitor can accept; transfer when valid_i && ready_o.
- add1_i  in  DATA_W  operand A.
- add2_i  in  DATA_W  operand B.
- approx_i  in  DATA_W+1  approximate adder result for add1_i+add2_i.
- clear_i  in  1  synchronous clear of pipeline and statistics.
- ed_valid_o  out  1  one-cycle pulse: ed_o/err_flag_o valid.
- ed_o  out  DATA_W+1  |exact - approx| for the retiring sample.
- err_flag_o  out  1  ed_o != 0.
- sample_cnt_o  out  CNT_W  samples retired since reset/clear.
- err_cnt_o  out  CNT_W  samples with nonzero ED.
- max_ed_o  out  DATA_W+1  maximum ED seen.
- sum_ed_o  out  ACC_W  running sum of ED, saturating.
- sat_o  out  1  a statistic has saturated; sticky until clear/reset.

Behaviour:
- Reset (rst_ni=0, async): all outputs and pipeline valids are 0, state=RUN, ready_o=0 while in reset.
- State machine:
  - RUN: ready_o=1 unless clear_i.
  - SAT: ready_o=0, no samples accepted; entered when sat_o sets.
  - CLEAR (one cycle): ready_o=0, pipeline flushed, all statistics zeroed.
  - Transitions: RUN→SAT on saturation; any→CLEAR on clear_i; CLEAR→RUN when clear_i drops (stays in CLEAR while clear_i is held).
- Stage 1 (cycle of accept +1):
  - Registers exact = zero-extended add1_i + add2_i (DATA_W+1 bits, carry kept) and approx_i.
  - Registers valid.
- Stage 2 (accept +2):
  - ed_o = exact>=approx ? exact-approx : approx-exact (unsigned; no truncation).
  - ed_valid_o pulses 1 cycle. Statistics update in the same edge; outputs are registered.
  - sample_cnt +1; err_cnt +1 if ED!=0; max_ed = max(max_ed, ED); sum_ed += ED.
- Latency: sample accepted at edge N → ed_o/statistics visible after edge N+2. Throughput: 1 sample/cycle in RUN. No backpressure inside the pipeline.
- Saturation:
  - sample_cnt reaching all-ones, or sum_ed overflowing, sets sat_o.
  - On overflow sum_ed clamps to all-ones.
  - Counters never wrap.
  - Samples already in flight when SAT is entered still retire. Further increments are blocked, and those counts are lost (sat_o flags this).
- clear_i:
  - Priority over everything, including a simultaneous stage-2 update (the update is discarded).
  - Flushes both stages, so no ed_valid_o pulse follows.
  - Samples presented with valid_i during clear are not accepted (ready_o=0).
- valid_i while ready_o=0: ignored; the upstream must hold the sample.
- Reset mid-pipeline: in-flight samples are discarded; no ed_valid_o after release.
- X on data inputs when valid_i=0 must not propagate into the statistics.

Decomposition:
- Shared package approx_arith_pkg:
  - DATA_W default constant.
  - Monitor state enum {RUN, SAT, CLEAR}.
  - Function abs_diff(a, b).
- One sub-module: approx_err_stats (stage-2 accumulator/counter bank with saturation), instantiated once.
- The top holds the handshake, state machine and stage 1.

Test Plan:
- Exact match: add1=0x5555_5555, add2=0xAAAA_AAAA, approx=0x0_FFFF_FFFF → two cycles later ed_o=0, err_flag_o=0, sample_cnt=1, err_cnt=0.
- Approx low: same operands, approx=0x0_FFFF_FF00 → ed_o=0xFF, err_cnt=1, max_ed=0xFF, sum_ed=0xFF.
- Approx high plus carry:
  - add1=0x0000_0001, add2=0xDEAF_BEEF, approx=0x0_DEAF_BFF0 → ed_o=0x100.
  - Then add1=0x8051_9860, add2=0x8086_BA3E, approx=0x1_00D8_529E → ed_o=0. Totals: sample_cnt=2, max_ed=0x100, sum_ed=0x100.
- Back-to-back stream of 10 samples with valid_i held high → ed_valid_o high 10 consecutive cycles starting 2 cycles after the first accept; sample_cnt=10.
- Saturation with CNT_W=4: 15 error-free samples → sample_cnt=0xF, sat_o=1, ready_o=0. A 16th presented sample is not accepted and the counter stays 0xF.
- Clear/reset:
  - clear_i asserted in the same cycle a sample is in stage 2 → no ed_valid_o pulse, all stats 0, ready_o=1 the cycle after clear_i drops.
  - rst_ni pulsed low mid-stream → all outputs 0 immediately, asynchronously.
